fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the single-cycle control unit.
- Holds the PC and issues requests to instruction memory over a req/rvalid handshake.
- Presents the fetched instruction, with op/funct3/funct7 pre-split, until execute commits.
- On commit, selects the next PC from PC+4 or the branch/jump target, using the control unit's PC-source decision.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit_pc_next_sel.sv | 33 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and its consumers.
// The FAULT state exists only when FETCH_ALIGN_CHECK_EN is defined.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_HOLD  = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the execute-side view.
// fetch_fault is present only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_unit_if #(parameter int XLEN = 32);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            commit;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [63:0]     instret;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            fetch_fault;
`endif

  modport master (
    input  imem_rvalid, imem_rdata, pc_src, pc_target, commit,
    output imem_req, imem_addr, inst_valid, inst, op, funct3, funct7,
           pc, pc_plus4, instret
`ifdef FETCH_ALIGN_CHECK_EN
         , fetch_fault
`endif
  );

  modport slave (
    output imem_rvalid, imem_rdata, pc_src, pc_target, commit,
    input  imem_req, imem_addr, inst_valid, inst, op, funct3, funct7,
           pc, pc_plus4, instret
`ifdef FETCH_ALIGN_CHECK_EN
         , fetch_fault
`endif
  );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC mux: sequential pc+4 or target with bit 0 cleared.
// With FETCH_ALIGN_CHECK_EN it also flags a taken target with bit 1 set.
module pc_next_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next
`ifdef FETCH_ALIGN_CHECK_EN
, output logic            misaligned
`endif
);

  // Bit 0 of the target is discarded by design (JALR semantics).
  logic unused_tgt_lsb_s;
  assign unused_tgt_lsb_s = pc_target[0];

  // Next-PC selection
  always_comb begin
    pc_plus4 = pc + XLEN'(3'd4);
    if (pc_src) begin
      pc_next = {pc_target[XLEN-1:1], 1'b0};
    end else begin
      pc_next = pc_plus4;
    end
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = pc_src & pc_target[1];
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: FETCH -> WAIT -> HOLD loop feeding the control unit.
// Build option FETCH_ALIGN_CHECK_EN adds a sticky misaligned-target FAULT state.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e    state_r, state_s;
  logic            start_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     inst_r;
  logic            inst_valid_r;
  logic            imem_req_r;
  logic [63:0]     instret_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            capture_s;
  logic            commit_s;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misaligned_s;
  logic            fault_r;
`endif

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc        (pc_r),
    .pc_src    (bus.pc_src),
    .pc_target (bus.pc_target),
    .pc_plus4  (pc_plus4_s),
    .pc_next   (pc_next_s)
`ifdef FETCH_ALIGN_CHECK_EN
  , .misaligned(misaligned_s)
`endif
  );

  assign capture_s = start_r & (state_r == ST_WAIT) & bus.imem_rvalid;
  assign commit_s  = (state_r == ST_HOLD) & bus.commit;

  // Next-state logic; start_r holds FETCH until the first edge after reset
  always_comb begin
    state_s = state_r;
    if (!start_r) begin
      state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: state_s = ST_WAIT;
        ST_WAIT: begin
          if (bus.imem_rvalid) state_s = ST_HOLD;
          else                 state_s = ST_WAIT;
        end
        ST_HOLD: begin
          if (bus.commit) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned_s) state_s = ST_FAULT;
            else              state_s = ST_FETCH;
`else
            state_s = ST_FETCH;
`endif
          end else begin
            state_s = ST_HOLD;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_FAULT: state_s = ST_FAULT;
`endif
        default: state_s = ST_FETCH;
      endcase
    end
  end

  // State, PC, instruction latch and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_FETCH;
      start_r      <= 1'b0;
      pc_r         <= RESET_PC;
      inst_r       <= NOP_INST;
      inst_valid_r <= 1'b0;
      imem_req_r   <= 1'b0;
      instret_r    <= 64'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      start_r      <= 1'b1;
      imem_req_r   <= (state_s == ST_FETCH);
      inst_valid_r <= (state_s == ST_HOLD);
      if (capture_s) inst_r <= bus.imem_rdata;
      if (commit_s) begin
        instret_r <= instret_r + 64'd1;
`ifdef FETCH_ALIGN_CHECK_EN
        if (misaligned_s) fault_r <= 1'b1;
        else              pc_r    <= pc_next_s;
`else
        pc_r <= pc_next_s;
`endif
      end
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.op         = inst_r[6:0];
  assign bus.funct3     = inst_r[14:12];
  assign bus.funct7     = inst_r[31:25];
  assign bus.pc         = pc_r;
  assign bus.pc_plus4   = pc_plus4_s;
  assign bus.instret    = instret_r;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fetch_fault = fault_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with variable
// latency, scoreboard queues for fetch addresses and returned words.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        stray = 1'b0;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] q_addr[$];
  logic [31:0] q_inst[$];
  logic [31:0] exp_pc;
  logic [63:0] exp_instret;
  int          req_cyc, valid_cyc, rel_cyc;

  // Instruction memory: latency counted in cycles from the request edge
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt = 0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end else if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      bus.imem_rvalid = 1'b0;
      if (mem_cnt != 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word;
        end
      end
      if (bus.imem_req) mem_cnt = mem_lat;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_fetch(input logic [31:0] w);
    mem_word = w;
    q_inst.push_back(w);
  endtask

  task automatic wait_req();
    logic [31:0] e;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) break;
      step();
    end
    chk("req_seen", {63'd0, bus.imem_req}, 64'd1);
    req_cyc = cyc;
    chk("addr_queue_nonempty", {63'd0, q_addr.size() != 0}, 64'd1);
    e = (q_addr.size() != 0) ? q_addr.pop_front() : 32'hFFFF_FFFF;
    chk("imem_addr", {32'd0, bus.imem_addr}, {32'd0, e});
  endtask

  task automatic wait_valid();
    logic [31:0] w;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid === 1'b1) break;
      step();
    end
    chk("valid_seen", {63'd0, bus.inst_valid}, 64'd1);
    valid_cyc = cyc;
    chk("inst_queue_nonempty", {63'd0, q_inst.size() != 0}, 64'd1);
    w = (q_inst.size() != 0) ? q_inst.pop_front() : 32'hFFFF_FFFF;
    chk("inst",     {32'd0, bus.inst},     {32'd0, w});
    chk("op",       {57'd0, bus.op},       {57'd0, w[6:0]});
    chk("funct3",   {61'd0, bus.funct3},   {61'd0, w[14:12]});
    chk("funct7",   {57'd0, bus.funct7},   {57'd0, w[31:25]});
    chk("pc",       {32'd0, bus.pc},       {32'd0, exp_pc});
    chk("pc_plus4", {32'd0, bus.pc_plus4}, {32'd0, exp_pc + 32'd4});
    chk("instret_hold", bus.instret, exp_instret);
  endtask

  // Commit the held instruction; the model computes the next fetch address
  task automatic do_commit(input logic src, input logic [31:0] tgt);
    logic [31:0] nxt;
    nxt = src ? {tgt[31:1], 1'b0} : exp_pc + 32'd4;
    q_addr.push_back(nxt);
    exp_pc = nxt;
    bus.pc_src    = src;
    bus.pc_target = tgt;
    bus.commit    = 1'b1;
    step();
    bus.commit    = 1'b0;
    bus.pc_src    = 1'($urandom);
    bus.pc_target = $urandom;
    exp_instret   = exp_instret + 64'd1;
    chk("instret_commit", bus.instret, exp_instret);
    chk("valid_drop", {63'd0, bus.inst_valid}, 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"},     {63'd0, bus.imem_req},   64'd0);
    chk({tag, "_valid"},   {63'd0, bus.inst_valid}, 64'd0);
    chk({tag, "_instret"}, bus.instret,             64'd0);
    chk({tag, "_pc"},      {32'd0, bus.pc},         64'h100);
    chk({tag, "_addr"},    {32'd0, bus.imem_addr},  64'h100);
    chk({tag, "_inst"},    {32'd0, bus.inst},       {32'd0, NOP_INST});
    chk({tag, "_op"},      {57'd0, bus.op},         {57'd0, OP_I_ALU});
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, "_fault"},   {63'd0, bus.fetch_fault}, 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.commit = 1'b0;
    bus.pc_src = 1'b0;
    bus.pc_target = 32'h0;
    exp_pc = 32'h100;
    exp_instret = 64'd0;
    repeat (2) step();
    reset_checks("reset");

    // First fetch after reset
    q_addr.push_back(32'h100);
    expect_fetch(32'h0050_0093);
    rst_n = 1'b1;
    rel_cyc = cyc;
    step();
    wait_req();
    chk("first_req_cycle", 64'(req_cyc - rel_cyc), 64'd1);
    wait_valid();
    chk("valid_latency", 64'(valid_cyc - req_cyc), 64'd2);

    // Sequential commit, then taken target with bit 0 set
    expect_fetch(32'h00A0_0113);
    do_commit(1'b0, 32'h0000_0777);
    wait_req();
    wait_valid();
    expect_fetch(32'h4020_8233);
    do_commit(1'b1, 32'h0000_0201);
    wait_req();
    wait_valid();

    // Execute stall with a stray response in HOLD
    for (int i = 0; i < 5; i++) begin
      if (i == 1) stray = 1'b1;
      if (i == 2) stray = 1'b0;
      step();
      chk("stall_inst",    {32'd0, bus.inst},       64'h4020_8233);
      chk("stall_pc",      {32'd0, bus.pc},         64'h200);
      chk("stall_req",     {63'd0, bus.imem_req},   64'd0);
      chk("stall_valid",   {63'd0, bus.inst_valid}, 64'd1);
      chk("stall_instret", bus.instret,             exp_instret);
    end

    // Slow memory; commit pulses while in WAIT are ignored
    mem_lat = 4;
    expect_fetch(32'h0000_006F);
    do_commit(1'b0, 32'h0);
    wait_req();
    step();
    bus.commit = 1'b1;
    bus.pc_src = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("wait_commit_pc",      {32'd0, bus.pc}, 64'h204);
    chk("wait_commit_instret", bus.instret,     exp_instret);
    wait_valid();
    chk("slow_latency", 64'(valid_cyc - req_cyc), 64'd5);

    // PC wrap at the top of the address space
    mem_lat = 1;
    expect_fetch(32'h0000_0013);
    do_commit(1'b1, 32'hFFFF_FFFD);
    wait_req();
    wait_valid();
    chk("wrap_plus4", {32'd0, bus.pc_plus4}, 64'h0);
    mem_lat = 4;
    expect_fetch(32'h1234_5537);
    do_commit(1'b0, 32'h0);
    wait_req();

    // Asynchronous reset mid-WAIT
    step();
    #1 rst_n = 1'b0;
    #1 reset_checks("async_reset");
    q_inst.delete();
    q_addr.delete();
    exp_pc = 32'h100;
    exp_instret = 64'd0;
    mem_lat = 1;
    step();
    q_addr.push_back(32'h100);
    expect_fetch(32'h0000_0067);
    rst_n = 1'b1;
    rel_cyc = cyc;
    step();
    wait_req();
    chk("rereset_req_cycle", 64'(req_cyc - rel_cyc), 64'd1);
    wait_valid();

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned taken target: sticky fault, pc frozen
    bus.pc_src    = 1'b1;
    bus.pc_target = 32'h0000_0302;
    bus.commit    = 1'b1;
    step();
    bus.commit    = 1'b0;
    exp_instret   = exp_instret + 64'd1;
    chk("fault_set",     {63'd0, bus.fetch_fault}, 64'd1);
    chk("fault_instret", bus.instret,              exp_instret);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fault_req",    {63'd0, bus.imem_req},    64'd0);
      chk("fault_valid",  {63'd0, bus.inst_valid},  64'd0);
      chk("fault_pc",     {32'd0, bus.pc},          64'h100);
      chk("fault_sticky", {63'd0, bus.fetch_fault}, 64'd1);
    end
`else
    expect_fetch(32'h0000_0013);
    do_commit(1'b1, 32'h0000_0302);
    wait_req();
    wait_valid();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
